// File: rtl/window_mean_filter_pkg.sv
// Shared types and helpers for the window mean filter.
// State encoding, channel count and window-size arithmetic.
package window_mean_filter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int NUM_CH = 3;

  function automatic int win_pixels(input int ws);
    return ws * ws;
  endfunction

endpackage

// File: rtl/window_mean_filter_channel_acc.sv
// One colour channel: running sum over the window
// and its constant-divisor mean.
module window_mean_filter_channel_acc #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int ACC_WIDTH     = 12,
  parameter int DIVISOR       = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     add_i,
  input  logic [CHANNEL_WIDTH-1:0] pix_i,
  output logic [CHANNEL_WIDTH-1:0] mean_o
);

  logic [ACC_WIDTH-1:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (add_i) begin
      acc_q <= acc_q + ACC_WIDTH'(pix_i);
    end
  end

  // Sum of N samples over N never exceeds one sample's range.
  assign mean_o =
    CHANNEL_WIDTH'(acc_q / ACC_WIDTH'(DIVISOR));

endmodule

// File: rtl/window_mean_filter.sv
// Window mean filter: gathers a WxW RGB neighbourhood
// after an FEN rising edge and returns its per-channel mean.
module window_mean_filter
  import window_mean_filter_pkg::*;
#(
  parameter int DATA_WIDTH    = 24,
  parameter int CHANNEL_WIDTH = 8,
  parameter int WINDOW_SIZE   = 3,
  parameter int ACC_WIDTH     = 12
) (
  input  logic                  Filter_CLK,
  input  logic                  Filter_RST,
  input  logic                  Filter_FEN,
  input  logic                  Filter_PIXVALID,
  input  logic [DATA_WIDTH-1:0] Filter_PIXDATA,
  output logic                  Filter_FDNE,
  output logic [DATA_WIDTH-1:0] Filter_FDATA,
  output logic                  Filter_BUSY
);

  localparam int WP    = win_pixels(WINDOW_SIZE);
  localparam int CNT_W = $clog2(WP + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WP - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    fen_q;
  logic [DATA_WIDTH-1:0]   fdata_q;
  logic [DATA_WIDTH-1:0]   mean;
  logic                    start;
  logic                    acc_clr;
  logic                    acc_add;

  assign start   = Filter_FEN & ~fen_q;
  assign acc_clr = (state_q == S_IDLE) & start;
  assign acc_add = (state_q == S_LOAD) & Filter_FEN
                 & Filter_PIXVALID;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    window_mean_filter_channel_acc #(
      .CHANNEL_WIDTH(CHANNEL_WIDTH),
      .ACC_WIDTH    (ACC_WIDTH),
      .DIVISOR      (WP)
    ) u_acc (
      .clk   (Filter_CLK),
      .rst_n (Filter_RST),
      .clr_i (acc_clr),
      .add_i (acc_add),
      .pix_i (Filter_PIXDATA[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
      .mean_o(mean[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH])
    );
  end

  always_ff @(posedge Filter_CLK or negedge Filter_RST) begin
    if (!Filter_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fen_q   <= 1'b0;
      fdata_q <= '0;
    end else begin
      fen_q <= Filter_FEN;
      unique case (1'b1)
        (state_q == S_IDLE): begin
          if (start) begin
            cnt_q   <= '0;
            state_q <= S_LOAD;
          end
        end
        (state_q == S_LOAD): begin
          // Abort wins over a same-cycle pixel.
          if (!Filter_FEN) begin
            state_q <= S_IDLE;
          end else if (Filter_PIXVALID) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) state_q <= S_CALC;
          end
        end
        (state_q == S_CALC): begin
          fdata_q <= mean;
          state_q <= S_DONE;
        end
        (state_q == S_DONE): begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Filter_FDNE  = (state_q == S_DONE);
  assign Filter_FDATA = fdata_q;
  assign Filter_BUSY  = (state_q == S_LOAD)
                      | (state_q == S_CALC);

endmodule

// File: tb/tb_window_mean_filter.sv
// Self-checking bench for window_mean_filter against
// a queue-based mean model.
module tb_window_mean_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fen;
  logic        pv;
  logic [23:0] pd;
  logic        dne;
  logic [23:0] fdata;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [23:0] last_exp = 24'h0;

  always #5 clk = ~clk;

  window_mean_filter dut (
    .Filter_CLK     (clk),
    .Filter_RST     (rst_n),
    .Filter_FEN     (fen),
    .Filter_PIXVALID(pv),
    .Filter_PIXDATA (pd),
    .Filter_FDNE    (dne),
    .Filter_FDATA   (fdata),
    .Filter_BUSY    (busy)
  );

  typedef logic [23:0] pix_q_t[$];

  function automatic logic [23:0] ref_mean(input pix_q_t q);
    int r = 0;
    int g = 0;
    int b = 0;
    int n;
    n = q.size();
    foreach (q[i]) begin
      r += int'(q[i][23:16]);
      g += int'(q[i][15:8]);
      b += int'(q[i][7:0]);
    end
    return {8'(r / n), 8'(g / n), 8'(b / n)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // FEN rise, one idle cycle, then pixels with random gaps.
  task automatic feed(input pix_q_t q, input int maxgap,
                      output bit busy_ok);
    int g;
    busy_ok = 1'b1;
    pv  = 1'b0;
    fen = 1'b1;
    tick();
    foreach (q[i]) begin
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (g) begin
        pv = 1'b0;
        pd = $urandom;
        tick();
        if (!busy) busy_ok = 1'b0;
      end
      pv = 1'b1;
      pd = q[i];
      tick();
      if (!busy) busy_ok = 1'b0;
    end
    pv = 1'b0;
    pd = $urandom;
  endtask

  // Starts on the negedge after the last pixel was accepted.
  task automatic wait_done(output int first, output int pulses,
                           output logic [23:0] data);
    first  = -1;
    pulses = 0;
    data   = 'x;
    for (int i = 0; i < 12; i++) begin
      if (dne) begin
        pulses++;
        if (first < 0) begin
          first = i;
          data  = fdata;
        end
      end
      tick();
    end
  endtask

  task automatic full_window(input pix_q_t q, input int maxgap,
                             input string name);
    bit busy_ok;
    int first;
    int pulses;
    logic [23:0] data;
    logic [23:0] exp;
    exp = ref_mean(q);
    feed(q, maxgap, busy_ok);
    wait_done(first, pulses, data);
    fen = 1'b0;
    tick();
    checks++;
    if (first != 1 || pulses != 1) begin
      failures++;
      $display("FAIL %s_done first=%0d pulses=%0d want first=1 pulses=1",
               name, first, pulses);
    end
    checks++;
    if (data !== exp || fdata !== exp) begin
      failures++;
      $display("FAIL %s_data at_dne=%h after=%h want %h",
               name, data, fdata, exp);
    end
    checks++;
    if (!busy_ok || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy load_ok=%0b idle=%b want 1/0",
               name, busy_ok, busy);
    end
    last_exp = exp;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fen   = 1'b0;
    pv    = 1'b0;
    pd    = '0;
    repeat (3) tick();
    checks++;
    if (dne !== 1'b0 || fdata !== 24'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset dne=%b fdata=%h busy=%b want 0/000000/0",
               dne, fdata, busy);
    end
    rst_n = 1'b1;
    tick();
    fen = 1'b1;
    fen = 1'b0;
    pv  = 1'b1;
    pd  = 24'hABCDEF;
    repeat (3) tick();
    pv = 1'b0;
    checks++;
    if (busy !== 1'b0 || dne !== 1'b0) begin
      failures++;
      $display("FAIL idle_pixvalid busy=%b dne=%b want 0/0", busy, dne);
    end
  endtask

  task automatic test_basic();
    pix_q_t q;
    repeat (9) q.push_back(24'h102030);
    full_window(q, 0, "basic");
  endtask

  task automatic test_gaps();
    pix_q_t q;
    for (int i = 0; i < 9; i++) q.push_back({8'(i), 8'hFF, 8'h00});
    full_window(q, 3, "gaps");
    checks++;
    if (last_exp !== 24'h04FF00) begin
      failures++;
      $display("FAIL gaps_model got=%h want 04ff00", last_exp);
    end
  endtask

  task automatic test_extremes();
    pix_q_t q;
    repeat (9) q.push_back(24'hFFFFFF);
    full_window(q, 1, "allff");
    q.delete();
    repeat (8) q.push_back(24'h090909);
    q.push_back(24'h000000);
    full_window(q, 0, "floor");
    checks++;
    if (fdata !== 24'h080808) begin
      failures++;
      $display("FAIL floor_const got=%h want 080808", fdata);
    end
  endtask

  task automatic test_random();
    pix_q_t q;
    for (int w = 0; w < 6; w++) begin
      q.delete();
      for (int i = 0; i < 9; i++) q.push_back(24'($urandom));
      full_window(q, 3, $sformatf("rand%0d", w));
    end
  endtask

  task automatic test_abort();
    pix_q_t q;
    bit busy_ok;
    int pulses = 0;
    logic [23:0] prev;
    prev = last_exp;
    for (int i = 0; i < 5; i++) q.push_back(24'($urandom));
    feed(q, 1, busy_ok);
    fen = 1'b0;
    pv  = 1'b1;
    pd  = 24'h123456;
    tick();
    pv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (dne) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0 || fdata !== prev) begin
      failures++;
      $display("FAIL abort pulses=%0d busy=%b fdata=%h want 0/0/%h",
               pulses, busy, fdata, prev);
    end
    q.delete();
    repeat (9) q.push_back(24'h010203);
    full_window(q, 2, "after_abort");
  endtask

  task automatic test_async_reset();
    pix_q_t q;
    bit busy_ok;
    for (int i = 0; i < 4; i++) q.push_back(24'($urandom));
    feed(q, 0, busy_ok);
    #2;
    rst_n = 1'b0;
    fen   = 1'b0;
    #1;
    checks++;
    if (fdata !== 24'h0 || dne !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset fdata=%h dne=%b busy=%b want 000000/0/0",
               fdata, dne, busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(24'($urandom));
    full_window(q, 2, "post_reset");
  endtask

  task automatic test_fen_hold();
    pix_q_t q;
    bit busy_ok;
    int first;
    int pulses;
    int extra = 0;
    int busy_hi = 0;
    logic [23:0] data;
    for (int i = 0; i < 9; i++) q.push_back(24'($urandom));
    feed(q, 0, busy_ok);
    wait_done(first, pulses, data);
    for (int i = 0; i < 20; i++) begin
      pv = 1'($urandom);
      pd = $urandom;
      tick();
      if (dne) extra++;
      if (busy) busy_hi++;
    end
    pv = 1'b0;
    checks++;
    if (pulses != 1 || extra != 0 || busy_hi != 0) begin
      failures++;
      $display("FAIL fen_hold pulses=%0d extra=%0d busy_cycles=%0d want 1/0/0",
               pulses, extra, busy_hi);
    end
    checks++;
    if (data !== ref_mean(q)) begin
      failures++;
      $display("FAIL fen_hold_data got=%h want %h", data, ref_mean(q));
    end
    fen = 1'b0;
    tick();
    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(24'($urandom));
    full_window(q, 1, "retrigger");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_extremes();
    test_random();
    test_abort();
    test_async_reset();
    test_fen_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
